// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch-stage constants and FSM state encoding
package fetch_pkg;

  localparam int FETCH_N     = 64;
  localparam int FETCH_IW    = 32;
  localparam int FETCH_DEPTH = 2;
  localparam int PC_STEP     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch bus: PC register, instruction memory and decode queue head
interface fetch_unit_if #(
  parameter int N  = fetch_pkg::FETCH_N,
  parameter int IW = fetch_pkg::FETCH_IW
) ();

  logic [N-1:0]  pc;
  logic          pc_load;
  logic [N-1:0]  pc_next;
  logic          redirect;
  logic [N-1:0]  redirect_pc;
  logic          req_valid;
  logic [N-1:0]  req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic [IW-1:0] resp_data;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [N-1:0]  inst_pc;
  logic          inst_ready;

  modport master (
    input  pc, redirect, redirect_pc, req_ready, resp_valid, resp_data, inst_ready,
    output pc_load, pc_next, req_valid, req_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output pc, redirect, redirect_pc, req_ready, resp_valid, resp_data, inst_ready,
    input  pc_load, pc_next, req_valid, req_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of {pc,inst} pairs; flush dominates push and pop
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W     = FETCH_N + FETCH_IW,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: one outstanding request, PC update mux, decode queue
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N     = FETCH_N,
  parameter int IW    = FETCH_IW,
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_nx;
  logic            drop;
  logic            drop_nx;
  logic            capture;
  logic            push;
  logic            pop;
  logic            flush;
  logic            pc_load;
  logic [N-1:0]    pc_next;
  logic            req_valid;
  logic [N-1:0]    req_pc;
  logic [CW-1:0]   count;
  logic [N+IW-1:0] head;
  logic            in_flight;
  logic            room;

  assign in_flight = (state == WAIT);
  assign room      = (int'(count) + int'(in_flight)) < DEPTH;
  assign pop       = bus.inst_ready && (count != '0) && !bus.redirect;

  always_comb begin
    state_nx  = state;
    drop_nx   = drop;
    capture   = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    pc_load   = 1'b0;
    pc_next   = '0;
    req_valid = 1'b0;
    if (bus.redirect) begin
      pc_load = 1'b1;
      pc_next = bus.redirect_pc;
      flush   = 1'b1;
    end
    case (state)
      IDLE: begin
        if (!bus.redirect && room) state_nx = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        // A request accepted alongside a redirect still returns a response that must be discarded.
        if (bus.redirect) begin
          state_nx = bus.req_ready ? WAIT : IDLE;
          drop_nx  = bus.req_ready;
        end else if (bus.req_ready) begin
          pc_load  = 1'b1;
          pc_next  = bus.pc + N'(PC_STEP);
          capture  = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect) begin
          if (bus.resp_valid) begin
            drop_nx  = 1'b0;
            state_nx = IDLE;
          end else begin
            drop_nx  = 1'b1;
          end
        end else if (bus.resp_valid) begin
          push     = !drop;
          drop_nx  = 1'b0;
          state_nx = ((int'(count) + int'(!drop) - int'(pop)) < DEPTH) ? REQ : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_nx;
      drop  <= drop_nx;
      if (capture) req_pc <= bus.pc;
    end
  end

  fetch_queue #(
    .W     (N + IW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({req_pc, bus.resp_data}),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

  assign bus.pc_load    = pc_load;
  assign bus.pc_next    = pc_next;
  assign bus.req_valid  = req_valid;
  assign bus.req_addr   = bus.pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_pc    = head[N+IW-1:IW];
  assign bus.inst       = head[IW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - fetch_unit bench with PC register, memory and stream reference model
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.N(64), .IW(32)) b ();

  fetch_unit #(.N(64), .IW(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  int          d0 = 0;
  logic [63:0] exp_pc = '0;
  logic [63:0] start_pc = '0;
  logic [63:0] pc_init = '0;
  logic        pc_set = 1'b0;
  logic [63:0] got[$];
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  logic [63:0] mem_addr = '0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [63:0] got_at(input int i);
    return (i < got.size()) ? got[i] : '1;
  endfunction

  // PC register: loads pc_next on pc_load, or a bench-forced start value.
  always @(posedge clk) begin
    if (pc_set) b.pc <= pc_init;
    else if (b.pc_load === 1'b1) b.pc <= b.pc_next;
  end

  // Instruction memory: returns inst_of(addr) mem_lat cycles after acceptance.
  always @(posedge clk) begin
    b.resp_valid <= 1'b0;
    if (b.req_valid === 1'b1 && b.req_ready === 1'b1) begin
      mem_addr <= b.req_addr;
      if (mem_lat <= 1) begin
        b.resp_valid <= 1'b1;
        b.resp_data  <= inst_of(b.req_addr);
        mem_busy     <= 1'b0;
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= mem_lat - 1;
      end
    end else if (mem_busy) begin
      if (mem_cnt == 1) begin
        b.resp_valid <= 1'b1;
        b.resp_data  <= inst_of(mem_addr);
        mem_busy     <= 1'b0;
      end
      mem_cnt <= mem_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the PC/request rules and the delivered stream, then advance the model.
  task automatic cycle();
    logic        pop;
    logic        redir;
    logic [63:0] rpc;
    @(negedge clk);
    #1;
    redir = b.redirect;
    rpc   = b.redirect_pc;
    if (redir) begin
      check("redir_load", b.pc_load, 1);
      check("redir_next", b.pc_next, rpc);
    end else if (b.req_valid === 1'b1 && b.req_ready === 1'b1) begin
      check("seq_load", b.pc_load, 1);
      check("seq_next", b.pc_next, b.pc + 64'd4);
    end else begin
      check("idle_load", b.pc_load, 0);
    end
    if (b.req_valid === 1'b1) check("req_addr", b.req_addr, b.pc);
    if (b.inst_valid === 1'b1) begin
      check("head_pc", b.inst_pc, exp_pc);
      check("head_inst", b.inst, inst_of(exp_pc));
    end
    pop = (b.inst_valid === 1'b1) && b.inst_ready && !redir;
    @(posedge clk);
    if (pop) begin
      got.push_back(exp_pc);
      exp_pc += 64'd4;
      delivered++;
    end
    if (redir) exp_pc = rpc;
    #1;
    if (redir) check("flush", b.inst_valid, 0);
  endtask

  task automatic restart(input logic [63:0] pc0);
    b.redirect   = 1'b0;
    b.req_ready  = 1'b0;
    b.inst_ready = 1'b0;
    reset        = 1'b1;
    pc_init      = pc0;
    pc_set       = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pc_set = 1'b0;
    reset  = 1'b0;
    exp_pc = pc0;
    got.delete();
  endtask

  task automatic wait_req(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      if (b.req_valid === 1'b1) break;
      cycle();
    end
    check(tag, b.req_valid, 1);
  endtask

  initial begin
    b.redirect    = 1'b0;
    b.redirect_pc = '0;
    b.req_ready   = 1'b0;
    b.inst_ready  = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_req_valid", b.req_valid, 0);
    check("rst_pc_load", b.pc_load, 0);
    check("rst_inst_valid", b.inst_valid, 0);
    check("rst_pc_next", b.pc_next, 0);

    // sequential stream from 0x1000
    restart(64'h1000);
    b.req_ready = 1'b1; b.inst_ready = 1'b1; mem_lat = 1;
    repeat (14) cycle();
    check("t2_pc0", got_at(0), 64'h1000);
    check("t2_pc1", got_at(1), 64'h1004);
    check("t2_pc2", got_at(2), 64'h1008);

    // decode stalled: queue fills to DEPTH and requests stop
    b.inst_ready = 1'b0;
    repeat (10) cycle();
    for (int i = 0; i < 4; i++) begin
      check("t3_full_valid", b.inst_valid, 1);
      check("t3_no_req", b.req_valid, 0);
      cycle();
    end
    b.req_ready = 1'b0; d0 = got.size(); b.inst_ready = 1'b1;
    repeat (6) cycle();
    check("t3_entries", 64'(got.size() - d0), 2);
    b.req_ready = 1'b1;
    repeat (14) cycle();
    check("t3_resume", 64'(got.size() - d0 >= 5), 1);

    // redirect while waiting on 0x1008
    restart(64'h1000);
    b.req_ready = 1'b1; b.inst_ready = 1'b1; mem_lat = 3;
    for (int i = 0; i < 40 && !(mem_busy && mem_addr == 64'h1008); i++) cycle();
    check("t4_setup", 64'(mem_busy && mem_addr == 64'h1008), 1);
    b.redirect = 1'b1; b.redirect_pc = 64'h2000; got.delete();
    cycle();
    b.redirect = 1'b0;
    repeat (25) cycle();
    check("t4_first", got_at(0), 64'h2000);
    check("t4_second", got_at(1), 64'h2004);

    // redirect in the same cycle as the request handshake
    restart(64'h1000);
    b.inst_ready = 1'b1; mem_lat = 1;
    wait_req("t5_req", 10);
    b.req_ready = 1'b1; b.redirect = 1'b1; b.redirect_pc = 64'h3000;
    cycle();
    b.redirect = 1'b0;
    for (int i = 0; i < 10 && b.req_valid !== 1'b1; i++) cycle();
    check("t5_req2", b.req_valid, 1);
    check("t5_addr", b.req_addr, 64'h3000);
    repeat (10) cycle();
    check("t5_first", got_at(0), 64'h3000);

    // wrap at top of address space, with a stalled memory
    restart(64'hFFFF_FFFF_FFFF_FFFC);
    b.inst_ready = 1'b1; mem_lat = 1;
    wait_req("t6_req", 10);
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_valid", b.req_valid, 1);
      check("t6_hold_addr", b.req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      check("t6_no_load", b.pc_load, 0);
      cycle();
    end
    b.req_ready = 1'b1;
    #1;
    check("t6_wrap_load", b.pc_load, 1);
    check("t6_wrap_next", b.pc_next, 64'h0);
    repeat (11) cycle();
    check("t6_first", got_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_second", got_at(1), 64'h0);

    // asynchronous reset in the middle of a wait
    restart(64'h1000);
    b.req_ready = 1'b1; mem_lat = 3;
    for (int i = 0; i < 40 && !(b.inst_valid === 1'b1 && mem_busy); i++) cycle();
    check("t1_setup", 64'(b.inst_valid === 1'b1 && mem_busy), 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t1_req_valid", b.req_valid, 0);
    check("t1_inst_valid", b.inst_valid, 0);
    check("t1_pc_load", b.pc_load, 0);
    @(posedge clk);
    #1;
    check("t1_idle", b.req_valid, 0);
    reset = 1'b0; start_pc = b.pc; exp_pc = b.pc; got.delete(); b.inst_ready = 1'b1;
    repeat (25) cycle();
    check("t1_restart", got_at(0), start_pc);

    // randomized traffic against the stream model
    restart(64'h0000_0000_8000_0000);
    d0 = delivered;
    repeat (1500) begin
      b.req_ready   = ($urandom_range(0, 3) != 0);
      b.inst_ready  = ($urandom_range(0, 2) != 0);
      mem_lat       = $urandom_range(1, 3);
      b.redirect    = ($urandom_range(0, 19) == 0);
      b.redirect_pc = {$urandom, $urandom} & ~64'h3;
      cycle();
    end
    b.redirect = 1'b0;
    check("rand_progress", 64'(delivered - d0 > 50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
